snes_vector_hook: RTL and testbench

Parametrised vector-override engine for the SNES-Hook CPLD, successor to the single reset-vector hook. It tracks `NUM_VEC` independent vector slots (reset, NMI, IRQ, BRK, …) on the raw SNES address bus and substitutes a 16-bit target address on the data bus when the CPU fetches that vector. Slots are configured at runtime through an 8-register window on the B-bus, so the bootloader can re-hook NMI/IRQ after boot. Slot 0 comes out of reset pre-armed as the boot hook.

---
 rtl/snes_hook_pkg.sv | 32 +++
 rtl/snes_bus_sync.sv | 31 +++
 rtl/snes_vec_slot.sv | 91 +++++++++
 rtl/snes_vector_hook.sv | 197 +++++++++++++++++++
 tb/tb_snes_vector_hook.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snes_hook_pkg.sv
// Shared types and constants for the SNES vector-override engine.
// Slot state encodings, config window offsets and CTRL bit positions.
package snes_hook_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_WAIT_LO  = 2'd1,
        ST_DRV_LO   = 2'd2,
        ST_DRV_HI   = 2'd3
    } slot_state_t;

    localparam logic [2:0] OFF_SEL     = 3'd0;
    localparam logic [2:0] OFF_VADDR_L = 3'd1;
    localparam logic [2:0] OFF_VADDR_H = 3'd2;
    localparam logic [2:0] OFF_TGT_L   = 3'd3;
    localparam logic [2:0] OFF_TGT_H   = 3'd4;
    localparam logic [2:0] OFF_CTRL    = 3'd5;
    localparam logic [2:0] OFF_STATUS  = 3'd6;
    localparam logic [2:0] OFF_INFO    = 3'd7;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_PERSIST = 1;

    typedef struct packed {
        logic vaddr_l;
        logic vaddr_h;
        logic tgt_l;
        logic tgt_h;
        logic ctrl;
    } slot_wr_t;

endpackage

// File: rtl/snes_bus_sync.sv
// Two-flop synchronisers for the SNES bus strobes with edge detection.
// bus_latch marks the synchronised falling edge of the read strobe.
module snes_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pard_n,
    input  logic pawr_n,
    output logic bus_latch,
    output logic pard_rise,
    output logic pawr_rise
);

    logic [2:0] rd_q;
    logic [2:0] wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '1;
            wr_q <= '1;
        end else begin
            rd_q <= {rd_q[1:0], pard_n};
            wr_q <= {wr_q[1:0], pawr_n};
        end
    end

    // [1] is the synchronised level, [2] its previous value
    assign bus_latch = rd_q[2] & ~rd_q[1];
    assign pard_rise = ~rd_q[2] & rd_q[1];
    assign pawr_rise = ~wr_q[2] & wr_q[1];

endmodule

// File: rtl/snes_vec_slot.sv
// One vector slot: override FSM, vector/target registers and match outputs.
// The FSM steps only on bus_latch; config writes override it at any time.
module snes_vec_slot
    import snes_hook_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] RST_VADDR = 16'h0000,
    parameter logic [15:0] RST_TGT   = 16'h0000,
    parameter bit          RST_ARMED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              bus_latch,
    input  logic              blocked,
    input  slot_wr_t          wr,
    input  logic [7:0]        wr_data,
    output logic              drive_lo,
    output logic              drive_hi,
    output logic [ADDR_W-1:0] vaddr,
    output logic [15:0]       tgt,
    output logic [7:0]        ctrl,
    output logic              hit_pulse
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    slot_state_t       state;
    logic              persist;
    logic [ADDR_W-1:0] vnext;
    logic              match_lo;
    logic              match_hi;
    logic [15:0]       v16;
    logic [15:0]       vl_new;
    logic [15:0]       vh_new;

    assign vnext    = vaddr + ONE;
    assign match_lo = (addr == vaddr);
    assign match_hi = (addr == vnext);

    assign drive_lo = match_lo &
                      (state == ST_WAIT_LO || state == ST_DRV_LO);
    assign drive_hi = match_hi &
                      (state == ST_DRV_LO || state == ST_DRV_HI);

    assign ctrl = {6'b0, persist, state != ST_DISARMED};

    // Bits above ADDR_W fall away on truncation and read back as zero
    assign v16    = 16'(vaddr);
    assign vl_new = {v16[15:8], wr_data};
    assign vh_new = {wr_data, v16[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr     <= RST_VADDR[ADDR_W-1:0];
            tgt       <= RST_TGT;
            persist   <= 1'b0;
            state     <= RST_ARMED ? ST_WAIT_LO : ST_DISARMED;
            hit_pulse <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;
            if (wr.vaddr_l) vaddr <= vl_new[ADDR_W-1:0];
            if (wr.vaddr_h) vaddr <= vh_new[ADDR_W-1:0];
            if (wr.tgt_l)   tgt[7:0]  <= wr_data;
            if (wr.tgt_h)   tgt[15:8] <= wr_data;
            if (wr.ctrl) begin
                persist <= wr_data[CTRL_PERSIST];
                state   <= wr_data[CTRL_ARM] ? ST_WAIT_LO : ST_DISARMED;
            end else if (bus_latch) begin
                case (state)
                    ST_WAIT_LO: begin
                        // A lower slot claiming this fetch keeps us waiting
                        if (match_lo && !blocked) state <= ST_DRV_LO;
                    end
                    ST_DRV_LO: begin
                        if (match_hi)       state <= ST_DRV_HI;
                        else if (!match_lo) state <= ST_WAIT_LO;
                    end
                    ST_DRV_HI: begin
                        if (!match_hi) begin
                            state     <= persist ? ST_WAIT_LO : ST_DISARMED;
                            hit_pulse <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/snes_vector_hook.sv
// Multi-slot SNES vector hook: slot array, priority drive mux and
// an 8-register B-bus config window for runtime re-hooking.
module snes_vector_hook
    import snes_hook_pkg::*;
#(
    parameter int          NUM_VEC    = 4,
    parameter int          ADDR_W     = 8,
    parameter logic [7:0]  CFG_BASE   = 8'hF0,
    parameter logic [15:0] BOOT_VADDR = 16'h00FC,
    parameter logic [15:0] BOOT_TGT   = 16'h2184
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    output logic               data_oe,
    input  logic               PARD_n,
    input  logic               PAWR_n,
    output logic [NUM_VEC-1:0] hook_hit
);

    localparam logic [ADDR_W-1:0] CFG_A = ADDR_W'(CFG_BASE);

    logic bus_latch;
    logic pard_rise;
    logic pawr_rise;

    snes_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .pard_n    (PARD_n),
        .pawr_n    (PAWR_n),
        .bus_latch (bus_latch),
        .pard_rise (pard_rise),
        .pawr_rise (pawr_rise)
    );

    logic       in_window;
    logic [2:0] off;
    logic       cfg_rd;

    assign in_window = (addr[ADDR_W-1:3] == CFG_A[ADDR_W-1:3]);
    assign off       = addr[2:0];
    assign cfg_rd    = !PARD_n && in_window;

    logic [2:0]         cap_off;
    logic [7:0]         cap_data;
    logic               pend;
    logic               commit;
    logic [7:0]         sel;
    logic               rd_stat;
    logic [NUM_VEC-1:0] hit;

    logic [NUM_VEC-1:0] drv_lo;
    logic [NUM_VEC-1:0] drv_hi;
    logic [NUM_VEC-1:0] blocked;
    logic [NUM_VEC-1:0] hit_pulse;
    logic [ADDR_W-1:0]  vaddr_arr [NUM_VEC];
    logic [15:0]        tgt_arr   [NUM_VEC];
    logic [7:0]         ctrl_arr  [NUM_VEC];
    slot_wr_t           wr_arr    [NUM_VEC];

    assign commit   = pawr_rise && pend;
    assign hook_hit = hit_pulse;

    // Last bus value seen while the write strobe is low is what commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_off  <= '0;
            cap_data <= '0;
            pend     <= 1'b0;
            sel      <= '0;
        end else begin
            if (!PAWR_n && in_window) begin
                cap_off  <= off;
                cap_data <= data_in;
                pend     <= 1'b1;
            end else if (pawr_rise) begin
                pend <= 1'b0;
            end
            if (commit && cap_off == OFF_SEL) sel <= cap_data;
        end
    end

    // A hit landing on the clear cycle survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_stat <= 1'b0;
            hit     <= '0;
        end else begin
            if (cfg_rd && off == OFF_STATUS) rd_stat <= 1'b1;
            else if (pard_rise)             rd_stat <= 1'b0;
            if (pard_rise && rd_stat) hit <= hit_pulse;
            else                      hit <= hit | hit_pulse;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VEC; i++) begin
            wr_arr[i] = '0;
            if (commit && sel == 8'(i)) begin
                wr_arr[i].vaddr_l = (cap_off == OFF_VADDR_L);
                wr_arr[i].vaddr_h = (cap_off == OFF_VADDR_H);
                wr_arr[i].tgt_l   = (cap_off == OFF_TGT_L);
                wr_arr[i].tgt_h   = (cap_off == OFF_TGT_H);
                wr_arr[i].ctrl    = (cap_off == OFF_CTRL);
            end
        end
    end

    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < NUM_VEC; i++) begin
            blocked[i] = acc;
            acc        = acc | drv_lo[i] | drv_hi[i];
        end
    end

    for (genvar i = 0; i < NUM_VEC; i++) begin : g_slot
        snes_vec_slot #(
            .ADDR_W    (ADDR_W),
            .RST_VADDR ((i == 0) ? BOOT_VADDR : 16'h0000),
            .RST_TGT   ((i == 0) ? BOOT_TGT : 16'h0000),
            .RST_ARMED (i == 0)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .addr      (addr),
            .bus_latch (bus_latch),
            .blocked   (blocked[i]),
            .wr        (wr_arr[i]),
            .wr_data   (cap_data),
            .drive_lo  (drv_lo[i]),
            .drive_hi  (drv_hi[i]),
            .vaddr     (vaddr_arr[i]),
            .tgt       (tgt_arr[i]),
            .ctrl      (ctrl_arr[i]),
            .hit_pulse (hit_pulse[i])
        );
    end

    logic [15:0] sv16;
    logic [15:0] st;
    logic [7:0]  sc;
    logic [7:0]  status8;
    logic [7:0]  rd_val;

    always_comb begin
        sv16    = '0;
        st      = '0;
        sc      = '0;
        status8 = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            if (sel == 8'(i)) begin
                sv16 = 16'(vaddr_arr[i]);
                st   = tgt_arr[i];
                sc   = ctrl_arr[i];
            end
        end
        status8[NUM_VEC-1:0] = hit;
        rd_val = '0;
        case (off)
            OFF_SEL:     rd_val = sel;
            OFF_VADDR_L: rd_val = sv16[7:0];
            OFF_VADDR_H: rd_val = sv16[15:8];
            OFF_TGT_L:   rd_val = st[7:0];
            OFF_TGT_H:   rd_val = st[15:8];
            OFF_CTRL:    rd_val = sc;
            OFF_STATUS:  rd_val = status8;
            OFF_INFO:    rd_val = {5'b0, 3'(NUM_VEC - 1)};
            default:     rd_val = '0;
        endcase
    end

    logic       slot_oe;
    logic [7:0] slot_d;

    // Walk downwards so the lowest matching index is the one left standing
    always_comb begin
        slot_oe = 1'b0;
        slot_d  = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (drv_lo[i] || drv_hi[i]) begin
                slot_oe = 1'b1;
                slot_d  = drv_lo[i] ? tgt_arr[i][7:0] : tgt_arr[i][15:8];
            end
        end
    end

    assign data_oe  = rst_n && (cfg_rd || slot_oe);
    assign data_out = !rst_n  ? 8'h00  :
                      cfg_rd  ? rd_val :
                      slot_oe ? slot_d : 8'h00;

endmodule

// File: tb/tb_snes_vector_hook.sv
// Bench for snes_vector_hook: directed vector tables, corner sequences,
// and a randomized fetch stream checked against a slot progress model.
module tb_snes_vector_hook;
    import snes_hook_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       PARD_n;
    logic       PAWR_n;
    logic [3:0] hook_hit;

    snes_vector_hook dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .PARD_n   (PARD_n),
        .PAWR_n   (PAWR_n),
        .hook_hit (hook_hit)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int hits[4] = '{0, 0, 0, 0};

    always @(negedge clk)
        if (rst_n === 1'b1)
            for (int i = 0; i < 4; i++)
                if (hook_hit[i] === 1'b1) hits[i]++;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic       oe;
        logic [7:0] d;
    } vec_t;

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fetch(input logic [7:0] a, output logic oe,
                         output logic [7:0] d);
        addr   = a;
        PARD_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        oe = data_oe;
        d  = data_out;
        PARD_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic [7:0] a,
                             input logic eoe, input logic [7:0] ed);
        logic       oe;
        logic [7:0] d;
        fetch(a, oe, d);
        check({name, "_oe"}, 16'(oe), 16'(eoe));
        check({name, "_d"}, 16'(d), 16'(ed));
    endtask

    task automatic cfg_wr(input logic [2:0] o, input logic [7:0] v);
        addr    = 8'hF0 | 8'(o);
        data_in = v;
        PAWR_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        PAWR_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic cfg_rd(input logic [2:0] o, output logic [7:0] d);
        addr   = 8'hF0 | 8'(o);
        PARD_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d = data_oe ? data_out : 8'hXX;
        PARD_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input string name, input logic [2:0] o,
                          input logic [7:0] exp);
        logic [7:0] d;
        cfg_rd(o, d);
        check(name, 16'(d), 16'(exp));
    endtask

    vec_t boot_v[5];
    vec_t pers_v[6];

    // Randomized model state: slot progress -1 off, 0 armed, 1 low served, 2 high served
    logic [7:0]  mv[4];
    logic [15:0] mt[4];
    bit          mp[4];
    int          ph[4];
    int          mh[4];
    int          base[4];
    logic [3:0]  mst;

    initial begin
        logic       oe;
        logic [7:0] d;
        boot_v = '{
            '{"boot_fc", 8'hFC, 1'b1, 8'h84},
            '{"boot_fd", 8'hFD, 1'b1, 8'h21},
            '{"boot_00", 8'h00, 1'b0, 8'h00},
            '{"boot_fc2", 8'hFC, 1'b0, 8'h00},
            '{"boot_fd2", 8'hFD, 1'b0, 8'h00}
        };
        pers_v = '{
            '{"p_ea1", 8'hEA, 1'b1, 8'h90},
            '{"p_eb1", 8'hEB, 1'b1, 8'h21},
            '{"p_sep1", 8'h00, 1'b0, 8'h00},
            '{"p_ea2", 8'hEA, 1'b1, 8'h90},
            '{"p_eb2", 8'hEB, 1'b1, 8'h21},
            '{"p_sep2", 8'h00, 1'b0, 8'h00}
        };

        rst_n   = 1'b0;
        PARD_n  = 1'b1;
        PAWR_n  = 1'b1;
        addr    = 8'hFC;
        data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", 16'(data_oe), 16'h0);
        check("rst_dout", 16'(data_out), 16'h0);
        check("rst_hook_hit", 16'(hook_hit), 16'h0);
        addr  = 8'h00;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++)
            chk_fetch(boot_v[i].name, boot_v[i].a, boot_v[i].oe, boot_v[i].d);
        check("boot_hits", 16'(hits[0]), 16'd1);
        chk_rd("boot_status", OFF_STATUS, 8'h01);
        chk_rd("boot_status_clr", OFF_STATUS, 8'h00);
        chk_rd("info", OFF_INFO, 8'h03);

        cfg_wr(OFF_SEL, 8'h01);
        cfg_wr(OFF_VADDR_L, 8'hEA);
        cfg_wr(OFF_VADDR_H, 8'h12);
        cfg_wr(OFF_TGT_L, 8'h90);
        cfg_wr(OFF_TGT_H, 8'h21);
        cfg_wr(OFF_CTRL, 8'h03);
        chk_rd("s1_vaddr_h", OFF_VADDR_H, 8'h00);
        chk_rd("s1_vaddr_l", OFF_VADDR_L, 8'hEA);
        chk_rd("s1_ctrl", OFF_CTRL, 8'h03);
        for (int i = 0; i < 6; i++)
            chk_fetch(pers_v[i].name, pers_v[i].a, pers_v[i].oe, pers_v[i].d);
        check("pers_hits", 16'(hits[1]), 16'd2);
        chk_rd("pers_status", OFF_STATUS, 8'h02);
        chk_rd("pers_status_clr", OFF_STATUS, 8'h00);

        cfg_wr(OFF_VADDR_L, 8'hEE);
        cfg_wr(OFF_TGT_L, 8'h11);
        cfg_wr(OFF_TGT_H, 8'h11);
        cfg_wr(OFF_CTRL, 8'h01);
        cfg_wr(OFF_SEL, 8'h02);
        cfg_wr(OFF_VADDR_L, 8'hEE);
        cfg_wr(OFF_TGT_L, 8'h22);
        cfg_wr(OFF_TGT_H, 8'h22);
        cfg_wr(OFF_CTRL, 8'h01);
        chk_fetch("prio_ee", 8'hEE, 1'b1, 8'h11);
        cfg_wr(OFF_SEL, 8'h01);
        cfg_wr(OFF_CTRL, 8'h00);
        chk_fetch("prio_ef_s2_waiting", 8'hEF, 1'b0, 8'h00);
        chk_rd("s1_ctrl_off", OFF_CTRL, 8'h00);
        chk_fetch("s2_ee", 8'hEE, 1'b1, 8'h22);
        chk_fetch("s2_ef", 8'hEF, 1'b1, 8'h22);
        chk_fetch("s2_00", 8'h00, 1'b0, 8'h00);
        check("s2_hits", 16'(hits[2]), 16'd1);
        chk_rd("s2_status", OFF_STATUS, 8'h04);

        cfg_wr(OFF_SEL, 8'h00);
        cfg_wr(OFF_CTRL, 8'h01);
        chk_fetch("ab_fc", 8'hFC, 1'b1, 8'h84);
        chk_fetch("ab_10", 8'h10, 1'b0, 8'h00);
        check("ab_nohit", 16'(hits[0]), 16'd1);
        chk_fetch("ab_fc2", 8'hFC, 1'b1, 8'h84);
        chk_fetch("ab_fd2", 8'hFD, 1'b1, 8'h21);
        chk_fetch("ab_00", 8'h00, 1'b0, 8'h00);
        check("ab_hits", 16'(hits[0]), 16'd2);

        cfg_wr(OFF_SEL, 8'h07);
        cfg_wr(OFF_TGT_L, 8'h55);
        chk_rd("sel7_tgt_l", OFF_TGT_L, 8'h00);
        chk_rd("sel7_sel", OFF_SEL, 8'h07);
        cfg_wr(OFF_SEL, 8'h00);
        chk_rd("sel7_s0_tgt", OFF_TGT_L, 8'h84);
        cfg_wr(OFF_SEL, 8'h01);
        chk_rd("sel7_s1_tgt", OFF_TGT_L, 8'h11);
        cfg_wr(OFF_SEL, 8'h02);
        chk_rd("sel7_s2_tgt", OFF_TGT_L, 8'h22);

        cfg_wr(OFF_SEL, 8'h00);
        cfg_wr(OFF_CTRL, 8'h01);
        chk_fetch("rr_fc", 8'hFC, 1'b1, 8'h84);
        addr   = 8'hFD;
        PARD_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rr_fd_oe", 16'(data_oe), 16'h1);
        check("rr_fd_d", 16'(data_out), 16'h21);
        rst_n = 1'b0;
        #1;
        check("rr_async_oe", 16'(data_oe), 16'h0);
        PARD_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_rd("rr_sel", OFF_SEL, 8'h00);
        chk_rd("rr_ctrl", OFF_CTRL, 8'h01);
        chk_rd("rr_tgt_l", OFF_TGT_L, 8'h84);
        chk_rd("rr_tgt_h", OFF_TGT_H, 8'h21);
        check("rr_nohit", 16'(hits[0]), 16'd2);
        chk_fetch("rr_fc2", 8'hFC, 1'b1, 8'h84);
        chk_fetch("rr_fd2", 8'hFD, 1'b1, 8'h21);
        chk_fetch("rr_00", 8'h00, 1'b0, 8'h00);
        check("rr_hits", 16'(hits[0]), 16'd3);

        cfg_rd(OFF_STATUS, d);
        mst = '0;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 8'h20 + 8'(32 * i);
            mt[i] = 16'($urandom);
            mp[i] = 1'($urandom_range(0, 1));
            ph[i] = 0;
            mh[i] = 0;
            base[i] = hits[i];
            cfg_wr(OFF_SEL, 8'(i));
            cfg_wr(OFF_VADDR_L, mv[i]);
            cfg_wr(OFF_TGT_L, mt[i][7:0]);
            cfg_wr(OFF_TGT_H, mt[i][15:8]);
            cfg_wr(OFF_CTRL, {6'b0, mp[i], 1'b1});
        end
        for (int n = 0; n < 200; n++) begin
            int         s;
            int         k;
            logic [7:0] a;
            logic       eoe;
            logic [7:0] ed;
            s = $urandom_range(0, 3);
            k = $urandom_range(0, 9);
            if (k == 9) begin
                mp[s] = 1'($urandom_range(0, 1));
                ph[s] = 0;
                cfg_wr(OFF_SEL, 8'(s));
                cfg_wr(OFF_CTRL, {6'b0, mp[s], 1'b1});
                continue;
            end
            a = (k < 4) ? mv[s] : (k < 8) ? mv[s] + 8'd1 : 8'h05;
            eoe = 1'b0;
            ed  = 8'h00;
            for (int i = 0; i < 4; i++) begin
                logic [7:0] hi_a;
                hi_a = mv[i] + 8'd1;
                if (ph[i] == 0 && a == mv[i]) ph[i] = 1;
                else if (ph[i] == 1 && a == hi_a) ph[i] = 2;
                else if (ph[i] == 1 && a != mv[i]) ph[i] = 0;
                else if (ph[i] == 2 && a != hi_a) begin
                    mh[i]++;
                    mst[i] = 1'b1;
                    ph[i] = mp[i] ? 0 : -1;
                end
                if ((ph[i] == 0 || ph[i] == 1) && a == mv[i]) begin
                    eoe = 1'b1;
                    ed  = mt[i][7:0];
                end else if ((ph[i] == 1 || ph[i] == 2) && a == hi_a) begin
                    eoe = 1'b1;
                    ed  = mt[i][15:8];
                end
            end
            fetch(a, oe, d);
            check($sformatf("rnd%0d_oe_a%h", n, a), 16'(oe), 16'(eoe));
            check($sformatf("rnd%0d_d_a%h", n, a), 16'(d), 16'(ed));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("rnd_hits%0d", i), 16'(hits[i] - base[i]),
                  16'(mh[i]));
        chk_rd("rnd_status", OFF_STATUS, {4'b0, mst});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
